// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-back data cache.
// Default geometry: 8 lines x 4 words, 32-bit byte addresses.
package dcache_pkg;

  localparam int DEF_LINES          = 8;
  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int DEF_ADDR_W         = 32;

  localparam int OFFSET_W = $clog2(DEF_WORDS_PER_LINE);
  localparam int INDEX_W  = $clog2(DEF_LINES);
  localparam int TAG_W    = DEF_ADDR_W - INDEX_W - OFFSET_W - 2;
  localparam int LINE_W   = DEF_WORDS_PER_LINE * 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    REFILL    = 2'd3
  } state_t;

  function automatic logic [63:0] addr_field(input logic [63:0] addr,
                                             input int unsigned lsb,
                                             input int unsigned width);
    return (addr >> lsb) & ((64'(1) << width) - 64'(1));
  endfunction

  function automatic logic [63:0] word_offset(input logic [63:0] addr, input int unsigned off_w);
    return addr_field(addr, 2, off_w);
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/dirty/tag/data arrays for the cache: combinational read, one write port
// that either merges a single word (sets dirty) or refills a whole line (clean).
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int LINES          = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int TAG_W_P        = 25
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [$clog2(LINES)-1:0]           i_rindex,
  output logic                               o_valid,
  output logic                               o_dirty,
  output logic [TAG_W_P-1:0]                 o_tag,
  output logic [WORDS_PER_LINE*32-1:0]       o_line,
  input  logic                               i_we,
  input  logic                               i_fill,
  input  logic [$clog2(LINES)-1:0]           i_windex,
  input  logic [TAG_W_P-1:0]                 i_wtag,
  input  logic [WORDS_PER_LINE*32-1:0]       i_wline,
  input  logic [$clog2(WORDS_PER_LINE)-1:0]  i_woffset,
  input  logic [31:0]                        i_wword
);

  localparam int IDX_W = $clog2(LINES);
  localparam int LN_W  = WORDS_PER_LINE * 32;

  logic [LINES-1:0] w_valid;
  logic [LINES-1:0] w_dirty;
  logic [TAG_W_P-1:0] w_tags [LINES];
  logic [LN_W-1:0]    w_lines [LINES];

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_line
      logic               r_valid;
      logic               r_dirty;
      logic [TAG_W_P-1:0] r_tag;
      logic [LN_W-1:0]    r_data;
      logic               w_sel;

      assign w_sel = i_we && (i_windex == IDX_W'(gi));

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_valid <= 1'b0;
          r_dirty <= 1'b0;
        end else if (w_sel) begin
          r_valid <= r_valid | i_fill;
          r_dirty <= !i_fill;
        end
      end

      // Tag and data carry no reset: they are meaningless while valid is clear.
      always_ff @(posedge i_clk) begin
        if (w_sel) begin
          if (i_fill) begin
            r_tag  <= i_wtag;
            r_data <= i_wline;
          end else begin
            r_data[32*i_woffset +: 32] <= i_wword;
          end
        end
      end

      assign w_valid[gi] = r_valid;
      assign w_dirty[gi] = r_dirty;
      assign w_tags[gi]  = r_tag;
      assign w_lines[gi] = r_data;
    end
  endgenerate

  assign o_valid = w_valid[i_rindex];
  assign o_dirty = w_dirty[i_rindex];
  assign o_tag   = w_tags[i_rindex];
  assign o_line  = w_lines[i_rindex];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache controller with block handshake to memory.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int LINES          = DEF_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int ADDR_W         = DEF_ADDR_W
) (
  input  logic                                      CLK,
  input  logic                                      RESET,
  input  logic                                      READ,
  input  logic                                      WRITE,
  input  logic [ADDR_W-1:0]                         ADDRESS,
  input  logic [31:0]                               WRITEDATA,
  output logic [31:0]                               READDATA,
  output logic                                      BUSYWAIT,
  output logic                                      MEM_READ,
  output logic                                      MEM_WRITE,
  output logic [ADDR_W-$clog2(WORDS_PER_LINE)-3:0]  MEM_ADDRESS,
  output logic [WORDS_PER_LINE*32-1:0]              MEM_WRITEDATA,
  input  logic [WORDS_PER_LINE*32-1:0]              MEM_READDATA,
  input  logic                                      MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]                               HIT_COUNT,
  output logic [31:0]                               MISS_COUNT
`endif
);

  localparam int OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int IDX_W   = $clog2(LINES);
  localparam int BLK_LSB = OFF_W + 2;
  localparam int BLK_W   = ADDR_W - BLK_LSB;
  localparam int TG_W    = BLK_W - IDX_W;
  localparam int LN_W    = WORDS_PER_LINE * 32;

  state_t             r_state;
  logic               r_mem_read;
  logic               r_mem_write;
  logic [BLK_W-1:0]   r_mem_address;
  logic [BLK_W-1:0]   r_miss_blk;
  logic [LN_W-1:0]    r_mem_writedata;
  logic [LN_W-1:0]    r_fill_line;

  logic               w_req;
  logic [OFF_W-1:0]   w_offset;
  logic [IDX_W-1:0]   w_index;
  logic [TG_W-1:0]    w_tag;
  logic [BLK_W-1:0]   w_blk;
  logic               w_valid;
  logic               w_dirty;
  logic [TG_W-1:0]    w_tag_rd;
  logic [LN_W-1:0]    w_line;
  logic               w_hit;
  logic               w_merge;
  logic               w_refill;
  logic               w_unused_addr;

  assign w_req         = READ | WRITE;
  assign w_offset      = OFF_W'(word_offset(64'(ADDRESS), OFF_W));
  assign w_index       = IDX_W'(addr_field(64'(ADDRESS), BLK_LSB, IDX_W));
  assign w_tag         = TG_W'(addr_field(64'(ADDRESS), BLK_LSB + IDX_W, TG_W));
  assign w_blk         = ADDRESS[ADDR_W-1:BLK_LSB];
  assign w_unused_addr = &{1'b0, ADDRESS[1:0]};

  assign w_hit    = w_valid && (w_tag_rd == w_tag);
  assign w_merge  = (r_state == IDLE) && WRITE && w_hit;
  assign w_refill = (r_state == REFILL);

  dcache_line_store #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .TAG_W_P        (TG_W)
  ) u_store (
    .i_clk     (CLK),
    .i_rst_n   (RESET),
    .i_rindex  (w_index),
    .o_valid   (w_valid),
    .o_dirty   (w_dirty),
    .o_tag     (w_tag_rd),
    .o_line    (w_line),
    .i_we      (w_merge | w_refill),
    .i_fill    (w_refill),
    .i_windex  (w_refill ? r_mem_address[IDX_W-1:0] : w_index),
    .i_wtag    (r_mem_address[BLK_W-1:IDX_W]),
    .i_wline   (r_fill_line),
    .i_woffset (w_offset),
    .i_wword   (WRITEDATA)
  );

  assign READDATA      = w_hit ? w_line[32*w_offset +: 32] : 32'd0;
  // Reset gates the stall so a CPU still holding a request sees BUSYWAIT drop at once.
  assign BUSYWAIT      = RESET && ((r_state != IDLE) || (w_req && !w_hit));
  assign MEM_READ      = r_mem_read;
  assign MEM_WRITE     = r_mem_write;
  assign MEM_ADDRESS   = r_mem_address;
  assign MEM_WRITEDATA = r_mem_writedata;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state         <= IDLE;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_address   <= '0;
      r_miss_blk      <= '0;
      r_mem_writedata <= '0;
      r_fill_line     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && !w_hit) begin
            r_miss_blk <= w_blk;
            if (w_valid && w_dirty) begin
              r_state         <= WRITEBACK;
              r_mem_write     <= 1'b1;
              r_mem_address   <= {w_tag_rd, w_index};
              r_mem_writedata <= w_line;
            end else begin
              r_state       <= ALLOCATE;
              r_mem_read    <= 1'b1;
              r_mem_address <= w_blk;
            end
          end
        end
        WRITEBACK: begin
          // A request abandoned during writeback only finishes the writeback.
          if (!MEM_BUSYWAIT) begin
            r_mem_write <= 1'b0;
            if (w_req) begin
              r_state       <= ALLOCATE;
              r_mem_read    <= 1'b1;
              r_mem_address <= r_miss_blk;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        ALLOCATE: begin
          if (!MEM_BUSYWAIT) begin
            r_state     <= REFILL;
            r_mem_read  <= 1'b0;
            r_fill_line <= MEM_READDATA;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;
  logic        r_reeval;

  // The hit seen right after a refill belongs to the miss already counted.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_reeval     <= 1'b0;
    end else begin
      r_reeval <= (r_state == REFILL);
      if ((r_state == IDLE) && w_req) begin
        if (!w_hit) begin
          if (r_miss_count != 32'hFFFF_FFFF) r_miss_count <= r_miss_count + 32'd1;
        end else if (!r_reeval) begin
          if (r_hit_count != 32'hFFFF_FFFF) r_hit_count <= r_hit_count + 32'd1;
        end
      end
    end
  end

  assign HIT_COUNT  = r_hit_count;
  assign MISS_COUNT = r_miss_count;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a fixed-latency block memory model.
// Counter checks are compiled in when DCACHE_STATS_EN is defined.
`timescale 1ns/1ps
module tb_dcache_controller;

  localparam int LAT = 5;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         READ = 1'b0;
  logic         WRITE = 1'b0;
  logic [31:0]  ADDRESS = '0;
  logic [31:0]  WRITEDATA = '0;
  logic [31:0]  READDATA;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
  logic [31:0]  HIT_COUNT;
  logic [31:0]  MISS_COUNT;
`endif

  dcache_controller dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
    ,
    .HIT_COUNT     (HIT_COUNT),
    .MISS_COUNT    (MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Block memory: every transfer takes LAT cycles, completing on the LAT-th edge.
  logic [127:0] mem [64];
  int           lat_cnt;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      lat_cnt <= 0;
    end else if (MEM_READ || MEM_WRITE) begin
      if (lat_cnt == LAT - 1) begin
        lat_cnt <= 0;
        if (MEM_WRITE) mem[MEM_ADDRESS[5:0]] <= MEM_WRITEDATA;
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      lat_cnt <= 0;
    end
  end

  assign MEM_BUSYWAIT = !((MEM_READ || MEM_WRITE) && (lat_cnt == LAT - 1));
  assign MEM_READDATA = mem[MEM_ADDRESS[5:0]];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-transaction observations of the memory side.
  logic         wb_seen, rd_seen;
  logic [27:0]  wb_addr, rd_addr;
  logic [127:0] wb_data;
  int           wb_cyc, rd_cyc;
  int           both_high = 0;

  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, output int stall, output logic [31:0] rdata);
    stall = 0;
    wb_seen = 1'b0; rd_seen = 1'b0;
    wb_addr = '0; rd_addr = '0; wb_data = '0;
    wb_cyc = -1; rd_cyc = -1;
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wd;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (MEM_WRITE && MEM_READ) both_high++;
      if (MEM_WRITE && !wb_seen) begin
        wb_seen = 1'b1; wb_addr = MEM_ADDRESS; wb_data = MEM_WRITEDATA; wb_cyc = c;
      end
      if (MEM_READ && !rd_seen) begin
        rd_seen = 1'b1; rd_addr = MEM_ADDRESS; rd_cyc = c;
      end
      if (!BUSYWAIT) break;
      stall++;
    end
    rdata = READDATA;
    @(posedge CLK);
    #1;
    READ = 1'b0; WRITE = 1'b0;
    $display("[TB] txn rd=%0d wr=%0d addr=0x%08h wdata=0x%08h stall=%0d rdata=0x%08h",
             rd, wr, addr, wd, stall, rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          st;
    logic [31:0] rdv;

    mem[1] = 128'h44444444_33333333_22222222_11111111;
    mem[2] = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
    mem[8] = 128'h83838383_82828282_81818181_80808080;
    mem[9] = 128'h99999993_99999992_99999991_99999990;
    mem[0] = 128'h03030303_02020202_01010101_00000000;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_busywait", BUSYWAIT, 1'b0);
    check("rst_mem_rw", {MEM_READ, MEM_WRITE}, 2'b00);
    check("rst_readdata", READDATA, 32'h0);
    check("rst_mem_addr_data", {MEM_ADDRESS, MEM_WRITEDATA}, '0);
    RESET = 1'b1;
    @(posedge CLK); #1;

    // 1: clean miss
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, st, rdv);
    check("t1_stall", st, 7);
    check("t1_rdata", rdv, 32'h1111_1111);
    check("t1_mem_read_addr", {rd_seen, rd_addr}, {1'b1, 28'h000_0001});
    check("t1_no_writeback", wb_seen, 1'b0);

    // 2: hit in the same line
    access(1'b1, 1'b0, 32'h0000_0014, 32'h0, st, rdv);
    check("t2_stall", st, 0);
    check("t2_rdata", rdv, 32'h2222_2222);

    // 3: write hit, then conflicting read forces a writeback
    access(1'b0, 1'b1, 32'h0000_0018, 32'hDEAD_BEEF, st, rdv);
    check("t3_write_stall", st, 0);
    access(1'b1, 1'b0, 32'h0000_0098, 32'h0, st, rdv);
    check("t3_stall", st, 12);
    check("t3_wb_addr", {wb_seen, wb_addr}, {1'b1, 28'h000_0001});
    check("t3_wb_word2", wb_data[95:64], 32'hDEAD_BEEF);
    check("t3_rd_addr", {rd_seen, rd_addr}, {1'b1, 28'h000_0009});
    check("t3_order", (wb_cyc >= 0) && (rd_cyc > wb_cyc), 1'b1);
    check("t3_rdata", rdv, 32'h9999_9992);
    check("t3_mem_updated", mem[1][95:64], 32'hDEAD_BEEF);
`ifdef DCACHE_STATS_EN
    check("t6_hit_count", HIT_COUNT, 32'd2);
    check("t6_miss_count", MISS_COUNT, 32'd2);
`endif

    // 4: reset during ALLOCATE
    READ = 1'b1; ADDRESS = 32'h0000_0010;
    @(negedge CLK);
    check("t4_miss_busy", BUSYWAIT, 1'b1);
    @(negedge CLK);
    check("t4_in_allocate", MEM_READ, 1'b1);
    #1 RESET = 1'b0;
    #1;
    check("t4_rst_mem_read", MEM_READ, 1'b0);
    check("t4_rst_busywait", BUSYWAIT, 1'b0);
    READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, st, rdv);
    check("t4_remiss_stall", st, 7);
    check("t4_remiss_rdata", rdv, 32'h1111_1111);
`ifdef DCACHE_STATS_EN
    check("t4_counts_after_reset", {HIT_COUNT, MISS_COUNT}, {32'd0, 32'd1});
`endif

    // 5: READ and WRITE together behave as a store
    access(1'b1, 1'b1, 32'h0000_0020, 32'h0000_0005, st, rdv);
    check("t5_store_stall", st, 7);
    access(1'b1, 1'b0, 32'h0000_0020, 32'h0, st, rdv);
    check("t5_read_back", {st[7:0], rdv}, {8'd0, 32'h0000_0005});
    access(1'b1, 1'b0, 32'h0000_0024, 32'h0, st, rdv);
    check("t5_neighbour_word", {st[7:0], rdv}, {8'd0, 32'hC1C1_C1C1});

    // Index wrap: 0x00 and 0x80 share line 0
    access(1'b1, 1'b0, 32'h0000_0080, 32'h0, st, rdv);
    check("wrap_80", {st[7:0], rdv}, {8'd7, 32'h8080_8080});
    access(1'b1, 1'b0, 32'h0000_0000, 32'h0, st, rdv);
    check("wrap_00", {st[7:0], rdv}, {8'd7, 32'h0000_0000});

    check("never_both_high", both_high, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU load/store port and the word-block data memory.
- The CPU stalls on BUSYWAIT; the cache runs a block-granular handshake to memory.
- The CPU drives it directly. The clock-cycle counter and the testbench observe the resulting stall cycles.

Parameters:
- LINES, 8, number of cache lines (power of two).
- WORDS_PER_LINE, 4, 32-bit words per line (power of two).
- ADDR_W, 32, CPU byte-address width.

Ports:
- CLK  in  1  system clock, rising-edge.
- RESET  in  1  asynchronous, active-low reset.
- READ  in  1  CPU load request, held until BUSYWAIT low.
- WRITE  in  1  CPU store request, held until BUSYWAIT low.
- ADDRESS  in  32  CPU byte address, word-aligned; bits [1:0] ignored.
- WRITEDATA  in  32  store data.
- READDATA  out  32  load data.
- BUSYWAIT  out  1  CPU stall.
- MEM_READ  out  1  block fetch request.
- MEM_WRITE  out  1  block writeback request.
- MEM_ADDRESS  out  28  memory block address (byte address [31:4]).
- MEM_WRITEDATA  out  128  victim block.
- MEM_READDATA  in  128  fetched block.
- MEM_BUSYWAIT  in  1  memory busy; a transfer completes on the first CLK edge where it is low while the request is high.

Behaviour:
- Address split (defaults): offset [3:2], index [6:4], tag [31:7] (25 bits).
- Per line: valid, dirty, tag, 128-bit data.
- Reset (RESET=0, asynchronous):
  - all valid and dirty bits cleared; state IDLE.
  - BUSYWAIT, MEM_READ, MEM_WRITE = 0; READDATA = 0; MEM_ADDRESS = 0; MEM_WRITEDATA = 0.
  - An in-flight memory transaction is abandoned. Memory is assumed to be reset by the same signal.
- Hit = valid[index] && tag match. Hit detect and READDATA are combinational from the stored line.
- States: IDLE, WRITEBACK, ALLOCATE, REFILL.
- IDLE:
  - No request: BUSYWAIT=0.
  - Request and hit: BUSYWAIT=0 in the same cycle, so load hit latency is 0 stall cycles.
  - Write hit: the word is updated and dirty set on the next CLK edge.
  - Request and miss: BUSYWAIT=1 combinationally. Next state is WRITEBACK if the victim is valid and dirty, otherwise ALLOCATE.
- WRITEBACK:
  - MEM_WRITE=1, MEM_ADDRESS={victim tag, index}, MEM_WRITEDATA=victim line.
  - Stays until MEM_BUSYWAIT=0 at an edge, then goes to ALLOCATE.
- ALLOCATE:
  - MEM_READ=1, MEM_ADDRESS=ADDRESS[31:4].
  - Stays until MEM_BUSYWAIT=0 at an edge, then goes to REFILL.
- REFILL (one cycle):
  - Line written with MEM_READDATA (captured on the ALLOCATE exit edge); valid=1, dirty=0, tag updated.
  - Returns to IDLE; BUSYWAIT stays 1 during REFILL.
  - The request is then re-evaluated in IDLE as a hit, and a store merges its word then.
- Clean miss stall = memory latency + 2 cycles. Dirty miss adds the writeback latency.
- MEM_READ and MEM_WRITE are never high together. Both drop to 0 in the cycle after completion.
- READ and WRITE both high: treated as WRITE.
- Request dropped mid-miss (CPU error): the FSM completes the current memory transfer, then returns to IDLE; the line remains allocated.
- Index wrap: addresses 0x0000_0000 and 0x0000_0080 map to index 0 and conflict.

Optional Feature:
- Macro DCACHE_STATS_EN.
- With it defined: adds output ports HIT_COUNT[31:0] and MISS_COUNT[31:0].
  - Each request accepted in IDLE increments exactly one counter: the hit counter on a first-evaluation hit, the miss counter on a miss.
  - The post-REFILL re-evaluation is not counted.
  - Counters saturate at 0xFFFF_FFFF and are cleared by reset.
- Without it: the ports are absent and no counter logic is generated.

Decomposition:
- Shared package dcache_pkg:
  - state enum (IDLE, WRITEBACK, ALLOCATE, REFILL).
  - derived widths: OFFSET_W, INDEX_W, TAG_W, LINE_W=WORDS_PER_LINE*32.
  - address-field extraction functions.
- One sub-module dcache_line_store:
  - holds the valid/dirty/tag/data arrays.
  - asynchronous clear on RESET.
  - combinational read port; single write port for either a word-merge or a full-line refill.
- The controller FSM stays in dcache_controller.

Test Plan:
1. Reset then READ 0x0000_0010: miss, MEM_READ with MEM_ADDRESS=0x0000001. Memory returns 0x44444444_33333333_22222222_11111111 after 5 cycles → READDATA=0x11111111; BUSYWAIT high for exactly 7 cycles.
2. After 1, READ 0x0000_0014 → hit, BUSYWAIT never high, READDATA=0x22222222 the same cycle.
3. WRITE 0xDEADBEEF to 0x0000_0018 (hit), then READ 0x0000_0098 (same index 1, different tag) → MEM_WRITE first with MEM_ADDRESS=0x0000001 and word 2 of MEM_WRITEDATA=0xDEADBEEF, then MEM_READ with MEM_ADDRESS=0x0000009.
4. Assert RESET=0 during ALLOCATE → MEM_READ and BUSYWAIT drop immediately; the following READ 0x0000_0010 misses again.
5. READ and WRITE both high to 0x0000_0020 with WRITEDATA=0x5 → behaves as a store; a later READ returns 0x5.
6. With DCACHE_STATS_EN defined, run scenarios 1–3 → HIT_COUNT=2, MISS_COUNT=2.
